prom_boot_loader: RTL and testbench
===================================

// Module: prom_boot_loader
// PURPOSE
//  Reads the whole contents of a 32x8 boot PROM (part_5600) and packs the bytes into 32-bit words.
//  Hands the words to the downstream boot writer, which loads them into microcode/main memory.
//  Drives the PROM address and chip enable. Waits a programmable number of settle cycles before
//  sampling, which covers the asynchronous PROM access delay.
// PARAMETERS
//  DEPTH   32  PROM bytes read per run (multiple of 4, power of 2)
//  AW      5   PROM address width, log2(DEPTH)
//  SETTLE  2   clk cycles between address change and data sample (>=1)
//  WAW     3   word index width, log2(DEPTH/4)
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  reset       in   1      synchronous, active-high reset
//  start       in   1      begin a load run (pulse or level; sampled in IDLE/DONE only)
//  prom_a      out  AW     PROM address (A4..A0)
//  prom_ce_n   out  1      PROM chip enable, active low
//  prom_d      in   8      PROM data (O7..O0); may be Z when prom_ce_n=1
//  word_out    out  32     assembled word
//  word_addr   out  WAW    index of word_out within the PROM (byte address / 4)
//  word_valid  out  1      word_out/word_addr valid
//  word_ready  in   1      downstream accepts word; transfer = valid & ready at clk edge
//  busy        out  1      run in progress
//  done        out  1      all DEPTH bytes delivered; holds until next start or reset
// BEHAVIOUR
//  Reset values: prom_a=0, prom_ce_n=1, word_out=0, word_addr=0, word_valid=0, busy=0, done=0.
//  The state machine also resets to IDLE, the byte lane to 0, and the settle counter to 0.
//  States:
//   IDLE: ce_n=1. start=1 -> FETCH with prom_a=0, lane=0, cnt=0.
//   FETCH: ce_n=0, prom_a held. cnt increments every cycle.
//    On the edge where cnt==SETTLE, prom_d is captured into word_out[8*lane+7:8*lane]
//    (little-endian: byte 4k+i -> lane i) and cnt is cleared.
//    If lane<3: lane++ and prom_a++, stay in FETCH.
//    If lane==3: go to PRESENT with word_valid=1 and word_addr=prom_a>>2.
//   PRESENT: ce_n=0. word_valid=1. word_out and word_addr stay stable until transfer.
//    word_valid never depends combinationally on word_ready.
//    On transfer: word_valid=0. If word_addr==DEPTH/4-1 -> DONE.
//    Otherwise prom_a++, lane=0, cnt=0, and go to FETCH.
//   DONE: ce_n=1, done=1, busy=0. start=1 -> clear done, start a new run as from IDLE.
//  busy=1 in FETCH and PRESENT.
//  Per-byte latency is SETTLE+1 cycles. Per-word latency is 4*(SETTLE+1) cycles to valid,
//  plus the handshake wait.
//  A fresh address is never sampled in fewer than SETTLE+1 cycles, including after a stall.
//  start while busy: ignored, with no effect on the address or data path.
//  word_ready asserted while word_valid=0: ignored.
//  prom_a wraps only by run completion; it never exceeds DEPTH-1.
//  Reset mid-run (any state): next cycle is the reset values above. A partial word is
//  discarded and is not presented.
//  Bytes not yet written in the current word keep their previous value. The bench checks
//  word_out only while word_valid=1.
// TESTING
//  PROM model with prom[i]=8'h10+i, SETTLE=2, word_ready tied 1.
//   start pulse at edge E0 -> prom_ce_n=0, prom_a=0 after E0; bytes sampled at E3, E6, E9, E12.
//   Then word_valid=1, word_out=32'h13121110, word_addr=0.
//  Same setup, full run -> 8 words, last word_out=32'h1F1E1D1C with word_addr=7.
//   Transfer at E104, then done=1, busy=0, prom_ce_n=1.
//  Backpressure: word_ready=0 for 10 cycles during word 2 -> word_out stays 32'h1B1A1918,
//   word_valid stays 1, and prom_a stays 11. After the accept, the next byte is sampled
//   exactly SETTLE+1 cycles later.
//  start asserted continuously during a run -> identical sequence to a single pulse.
//   After DONE, start -> done=0 and a second identical run.
//  reset asserted at the edge after byte 1 of word 3 is sampled -> all outputs at reset values.
//   A new start then re-delivers word 0 first.
//  SETTLE=1 build -> each byte sampled 2 cycles after its address change. Data still correct
//   with the PROM model at 10 ns delay and a 20 ns clock.

Source files
------------

// File: rtl/prom_boot_loader.sv
// Boot PROM loader: walks a byte-wide PROM, waits SETTLE cycles per address
// for the asynchronous access, packs bytes little-endian into 32-bit words and
// hands each word downstream over a valid/ready handshake.
module prom_boot_loader #(
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int SETTLE = 2,
  parameter int WAW    = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [AW-1:0]  prom_a,
  output logic           prom_ce_n,
  input  logic [7:0]     prom_d,
  output logic [31:0]    word_out,
  output logic [WAW-1:0] word_addr,
  output logic           word_valid,
  input  logic           word_ready,
  output logic           busy,
  output logic           done
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  SETTLE_C  = CW'(SETTLE);
  localparam logic [WAW-1:0] LAST_WORD = WAW'(DEPTH / 4 - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  prom_a_q, prom_a_d;
  logic           prom_ce_n_q, prom_ce_n_d;
  logic [31:0]    word_out_q, word_out_d;
  logic [WAW-1:0] word_addr_q, word_addr_d;
  logic           word_valid_q, word_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [1:0]     lane_q, lane_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Next-state and next-output logic; every output is produced from a flop.
  always_comb begin
    state_d      = state_q;
    prom_a_d     = prom_a_q;
    prom_ce_n_d  = prom_ce_n_q;
    word_out_d   = word_out_q;
    word_addr_d  = word_addr_q;
    word_valid_d = word_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = FETCH;
          prom_a_d    = '0;
          lane_d      = '0;
          cnt_d       = '0;
          prom_ce_n_d = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end
      end

      FETCH: begin
        if (cnt_q == SETTLE_C) begin
          // Lanes not yet written keep their old contents.
          word_out_d[8*lane_q +: 8] = prom_d;
          cnt_d = '0;
          if (lane_q == 2'd3) begin
            state_d      = PRESENT;
            word_valid_d = 1'b1;
            word_addr_d  = prom_a_q[AW-1:2];
          end else begin
            lane_d   = lane_q + 2'd1;
            prom_a_d = prom_a_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PRESENT: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          if (word_addr_q == LAST_WORD) begin
            state_d     = DONE;
            prom_a_d    = '0;
            prom_ce_n_d = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            state_d  = FETCH;
            prom_a_d = prom_a_q + 1'b1;
            lane_d   = '0;
            cnt_d    = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      prom_a_q     <= '0;
      prom_ce_n_q  <= 1'b1;
      word_out_q   <= '0;
      word_addr_q  <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lane_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      prom_a_q     <= prom_a_d;
      prom_ce_n_q  <= prom_ce_n_d;
      word_out_q   <= word_out_d;
      word_addr_q  <= word_addr_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
    end
  end

  assign prom_a     = prom_a_q;
  assign prom_ce_n  = prom_ce_n_q;
  assign word_out   = word_out_q;
  assign word_addr  = word_addr_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_prom_boot_loader.sv
// Self-checking bench for prom_boot_loader: a PROM array model, directed
// timing runs and randomized data/backpressure runs against a word model.
module tb_prom_boot_loader;

  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int SETTLE = 2;
  localparam int WAW    = 3;
  localparam int NW     = DEPTH / 4;
  localparam int LAT    = 4 * (SETTLE + 1);

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic           reset, start, word_ready;
  logic [AW-1:0]  prom_a;
  logic           prom_ce_n;
  logic [7:0]     prom_d;
  logic [31:0]    word_out;
  logic [WAW-1:0] word_addr;
  logic           word_valid, busy, done;

  logic           start1, word_ready1;
  logic [AW-1:0]  prom_a1;
  logic           prom_ce_n1;
  logic [7:0]     prom_d1;
  logic [31:0]    word_out1;
  logic [WAW-1:0] word_addr1;
  logic           word_valid1, busy1, done1;

  logic [7:0] mem [DEPTH];

  assign prom_d  = prom_ce_n  ? 8'hzz : mem[prom_a];
  assign prom_d1 = prom_ce_n1 ? 8'hzz : mem[prom_a1];

  prom_boot_loader #(.DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE), .WAW(WAW)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .prom_a(prom_a), .prom_ce_n(prom_ce_n), .prom_d(prom_d),
    .word_out(word_out), .word_addr(word_addr), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy), .done(done)
  );

  prom_boot_loader #(.DEPTH(DEPTH), .AW(AW), .SETTLE(1), .WAW(WAW)) u_dut_s1 (
    .clk(clk), .reset(reset), .start(start1),
    .prom_a(prom_a1), .prom_ce_n(prom_ce_n1), .prom_d(prom_d1),
    .word_out(word_out1), .word_addr(word_addr1), .word_valid(word_valid1),
    .word_ready(word_ready1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return {mem[4*k+3], mem[4*k+2], mem[4*k+1], mem[4*k]};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_prom_a"}, 32'(prom_a), 32'd0);
    chk({tag, "_ce_n"}, 32'(prom_ce_n), 32'd1);
    chk({tag, "_word_out"}, word_out, 32'd0);
    chk({tag, "_word_addr"}, 32'(word_addr), 32'd0);
    chk({tag, "_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // start_mode: 0 single pulse, 1 held high, 2 random level.
  // stall_word: word index held off for 10 cycles (-1 for none).
  // ready_rand: random ready while fetching and random short stalls.
  task automatic run_words(input int nwords, input int start_mode, input int stall_word,
                           input int ready_rand, output int edges);
    int hold;
    edges = 0;
    start = 1'b1;
    word_ready = 1'b0;
    tick();
    chk("start_ce_n", 32'(prom_ce_n), 32'd0);
    chk("start_prom_a", 32'(prom_a), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    for (int k = 0; k < nwords; k++) begin
      for (int j = 1; j <= LAT; j++) begin
        start = (start_mode == 1) ? 1'b1 : (start_mode == 2) ? 1'($urandom) : 1'b0;
        word_ready = ready_rand ? 1'($urandom) : 1'b1;
        tick();
        edges++;
        if (j < LAT) begin
          chk("fetch_valid", 32'(word_valid), 32'd0);
          chk("fetch_prom_a", 32'(prom_a), 32'(4*k + j/(SETTLE+1)));
        end else begin
          chk("word_valid", 32'(word_valid), 32'd1);
          chk("word_out", word_out, exp_word(k));
          chk("word_addr", 32'(word_addr), 32'(k));
          chk("word_prom_a", 32'(prom_a), 32'(4*k + 3));
        end
      end
      hold = ready_rand ? int'($urandom_range(0, 3)) : 0;
      if (k == stall_word) hold = 10;
      for (int h = 0; h < hold; h++) begin
        start = (start_mode == 1) ? 1'b1 : (start_mode == 2) ? 1'($urandom) : 1'b0;
        word_ready = 1'b0;
        tick();
        edges++;
        chk("stall_valid", 32'(word_valid), 32'd1);
        chk("stall_word_out", word_out, exp_word(k));
        chk("stall_prom_a", 32'(prom_a), 32'(4*k + 3));
      end
      word_ready = 1'b1;
      tick();
      edges++;
      chk("xfer_valid", 32'(word_valid), 32'd0);
      if (k == NW - 1) begin
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ce_n", 32'(prom_ce_n), 32'd1);
      end else begin
        chk("next_busy", 32'(busy), 32'd1);
        chk("next_prom_a", 32'(prom_a), 32'(4*(k+1)));
      end
    end
    start = 1'b0;
    word_ready = 1'b0;
  endtask

  initial begin
    int edges;
    int words;
    reset = 1'b1;
    start = 1'b0;
    word_ready = 1'b0;
    start1 = 1'b0;
    word_ready1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);

    tick();
    tick();
    reset = 1'b0;
    chk_reset_vals("reset");

    // Directed run with ready tied high: last transfer lands on E104.
    run_words(NW, 0, -1, 0, edges);
    chk("run_a_edges", 32'(edges), 32'd104);
    tick();
    chk("done_holds", 32'(done), 32'd1);

    // Second run after DONE with 10-cycle backpressure on word 2.
    run_words(NW, 0, 2, 0, edges);
    chk("run_b_edges", 32'(edges), 32'd114);

    // Start held high through the run behaves like a single pulse.
    run_words(NW, 1, -1, 0, edges);
    chk("run_c_edges", 32'(edges), 32'd104);

    // Random PROM contents, random start noise, random ready.
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    run_words(NW, 2, -1, 1, edges);

    // Reset right after byte 1 of word 3 is sampled.
    run_words(3, 0, -1, 0, edges);
    for (int j = 0; j < 2 * (SETTLE + 1); j++) tick();
    chk("mid_prom_a", 32'(prom_a), 32'd14);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("midreset");
    tick();
    chk("post_reset_busy", 32'(busy), 32'd0);
    run_words(NW, 2, -1, 1, edges);

    // SETTLE=1 build: each byte sampled 2 cycles after its address change.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j < 8) begin
        chk("s1_valid", 32'(word_valid1), 32'd0);
        chk("s1_prom_a", 32'(prom_a1), 32'(j / 2));
      end else begin
        chk("s1_first_valid", 32'(word_valid1), 32'd1);
        chk("s1_first_word", word_out1, exp_word(0));
        chk("s1_first_addr", 32'(word_addr1), 32'd0);
      end
    end
    word_ready1 = 1'b1;
    words = 1;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (word_valid1) begin
        chk("s1_word_addr", 32'(word_addr1), 32'(words));
        chk("s1_word_out", word_out1, exp_word(int'(word_addr1)));
        words++;
      end
      if (done1) break;
    end
    chk("s1_word_count", 32'(words), 32'(NW));
    chk("s1_done", 32'(done1), 32'd1);
    word_ready1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
